// File: rtl/iram_load_arbiter.sv
// iram_load_arbiter: shares the single-port IRAM between IF fetch and a program loader.
// Optional IRAM_LD_RESTART_EN: pulse pc_restart after a completed loader session.
module iram_load_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int BURST_MAX = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [31:0]       pc,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ack,
  output logic              ram_ena,
  output logic              ram_wena,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_indata,
  output logic              fetch_stall,
  output logic              fetch_valid,
  output logic [ADDR_W:0]   ld_count,
  output logic              pc_restart
);
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam logic [ADDR_W:0] LD_MAX = {1'b1, {ADDR_W{1'b0}}};
  typedef enum logic [1:0] {S_FETCH, S_LOAD, S_TURN} state_t;
  state_t state;
  logic [BW-1:0] burst_cnt;
  logic fair_blk;
  logic load;
  logic burst_end;
  logic unused_pc;
  assign unused_pc = ^{pc[31:ADDR_W+2], pc[1:0]};
  assign load = state == S_LOAD;
  // comb outputs are gated by rst_n so everything reads 0 while reset is held
  assign ld_ack = rst_n && load && ld_req;
  assign ram_ena = rst_n && (state == S_FETCH ? fetch_req : ld_ack);
  assign ram_wena = ld_ack;
  assign ram_addr = !rst_n ? '0 : load ? ld_addr : pc[ADDR_W+1:2];
  assign ram_indata = rst_n && load ? ld_data : '0;
  assign fetch_stall = rst_n && state != S_FETCH;
  assign burst_end = !ld_req || burst_cnt == BW'(BURST_MAX - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
      burst_cnt <= '0;
      fair_blk <= 1'b0;
      ld_count <= '0;
      fetch_valid <= 1'b0;
    end else begin
      fetch_valid <= state == S_FETCH && fetch_req;
      if (ld_ack) begin
        burst_cnt <= burst_cnt + 1'b1;
        if (ld_count != LD_MAX) ld_count <= ld_count + 1'b1;
      end
      case (state)
        S_FETCH: begin
          fair_blk <= 1'b0;
          if (ld_req && !fair_blk) state <= S_LOAD;
        end
        S_LOAD: if (burst_end) state <= S_TURN;
        default: begin
          state <= S_FETCH;
          fair_blk <= 1'b1;
          burst_cnt <= '0;
        end
      endcase
    end
  end
`ifdef IRAM_LD_RESTART_EN
  logic idle_end;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_end <= 1'b0;
      pc_restart <= 1'b0;
    end else begin
      if (load && burst_end) idle_end <= !ld_req;
      pc_restart <= state == S_TURN && idle_end;
    end
  end
`else
  assign pc_restart = 1'b0;
`endif
endmodule

// File: tb/tb_iram_load_arbiter.sv
// tb_iram_load_arbiter: randomized bench against a grant/turnaround reference model.
module tb_iram_load_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int BM = 16;
`ifdef IRAM_LD_RESTART_EN
  localparam int RST_EN = 1;
`else
  localparam int RST_EN = 0;
`endif
  logic clk = 0, rst_n = 0, fetch_req = 0, ld_req = 0;
  logic [31:0] pc = 0;
  logic [AW-1:0] ld_addr = 0;
  logic [DW-1:0] ld_data = 0;
  logic ld_ack, ram_ena, ram_wena, fetch_stall, fetch_valid, pc_restart;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_indata;
  logic [AW:0] ld_count;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  iram_load_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_MAX(BM)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .pc(pc), .ld_req(ld_req),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(ld_ack), .ram_ena(ram_ena),
    .ram_wena(ram_wena), .ram_addr(ram_addr), .ram_indata(ram_indata),
    .fetch_stall(fetch_stall), .fetch_valid(fetch_valid), .ld_count(ld_count),
    .pc_restart(pc_restart)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // model: pending loader writes plus grant bookkeeping
  logic [AW+DW-1:0] q[$];
  bit m_grant, m_turn, m_blk, m_idle, m_valid, m_restart, gaps, pres;
  int m_burst, m_total, pulses;
  function automatic void m_reset();
    m_grant = 0; m_turn = 0; m_blk = 0; m_idle = 0; m_valid = 0; m_restart = 0;
    m_burst = 0; m_total = 0;
  endfunction
  task automatic check_zero(input string tag);
    chk({tag, "_ack"}, ld_ack, 0);
    chk({tag, "_ena"}, ram_ena, 0);
    chk({tag, "_wena"}, ram_wena, 0);
    chk({tag, "_addr"}, ram_addr, 0);
    chk({tag, "_indata"}, ram_indata, 0);
    chk({tag, "_stall"}, fetch_stall, 0);
    chk({tag, "_valid"}, fetch_valid, 0);
    chk({tag, "_count"}, ld_count, 0);
    chk({tag, "_restart"}, pc_restart, 0);
  endtask
  task automatic push(input int n);
    for (int i = 0; i < n; i++) q.push_back({AW'($urandom), DW'($urandom)});
  endtask
  task automatic step(input bit fr, input logic [31:0] p);
    bit fetching, e_ack, e_ena;
    fetch_req = fr;
    pc = p;
    if (!pres && q.size() > 0) pres = !gaps || ($urandom % 3 != 0);
    ld_req = pres;
    if (pres) {ld_addr, ld_data} = q[0];
    else {ld_addr, ld_data} = '0;
    #1;
    fetching = !m_grant && !m_turn;
    e_ack = m_grant && ld_req;
    e_ena = fetching ? fr : e_ack;
    chk("ack", ld_ack, e_ack);
    chk("ena", ram_ena, e_ena);
    chk("wena", ram_wena, e_ack);
    if (e_ena) chk("addr", ram_addr, m_grant ? ld_addr : p[AW+1:2]);
    chk("indata", ram_indata, m_grant ? ld_data : '0);
    chk("stall", fetch_stall, !fetching);
    chk("valid", fetch_valid, m_valid);
    chk("count", ld_count, m_total > 256 ? 256 : m_total);
    chk("restart", pc_restart, m_restart);
    pulses += int'(pc_restart);
    m_valid = fetching && fr;
    m_restart = 0;
    if (fetching) begin
      if (ld_req && !m_blk) begin m_grant = 1; m_burst = 0; end
      m_blk = 0;
    end else if (m_grant) begin
      if (ld_req) begin
        m_burst++; m_total++;
        void'(q.pop_front());
        pres = 0;
      end
      if (!ld_req || m_burst == BM) begin m_grant = 0; m_turn = 1; m_idle = !ld_req; end
    end else begin
      m_turn = 0; m_blk = 1;
      m_restart = RST_EN != 0 && m_idle;
    end
    @(negedge clk);
  endtask
  initial begin
    int base, n;
    m_reset();
    q.push_back({8'd0, 32'h2408_0005});
    q.push_back({8'd1, 32'h2409_0003});
    q.push_back({8'd2, 32'h0109_5020});
    pres = 1; gaps = 0; pulses = 0;
    ld_req = 1; {ld_addr, ld_data} = q[0]; fetch_req = 1; pc = 32'h10;
    #2 check_zero("rst");
    @(negedge clk);
    #1 check_zero("rst_hold");
    rst_n = 1;
    #1;
    chk("pc_addr", ram_addr, 4);
    chk("pc_ena", ram_ena, 1);
    chk("no_ack_at_release", ld_ack, 0);
    for (int i = 0; i < 10; i++) step(1, 32'h10 + 32'(4 * i));
    chk("load3_count", ld_count, 3);
    pulses = 0;
    push(2);
    for (int i = 0; i < 10; i++) step(1'($urandom), $urandom);
    chk("sess2_pulses", pulses, RST_EN);
    pulses = 0;
    push(20);
    for (int i = 0; i < 30; i++) step(1, $urandom);
    chk("burst20_count", ld_count, 25);
    chk("burst20_pulses", pulses, RST_EN);
    push(5);
    base = m_total; n = 0;
    while (m_total < base + 2 && n < 40) begin step(1'($urandom), $urandom); n++; end
    chk("mid_reached", m_total - base, 2);
    rst_n = 0;
    #1 check_zero("mid_rst");
    m_reset();
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 20; i++) step(1'($urandom), $urandom);
    chk("after_rst_count", ld_count, 3);
    chk("after_rst_drain", q.size(), 0);
    gaps = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom % 8 == 0 && q.size() < 40) push(1 + $urandom % 20);
      step(1'($urandom % 4 != 0), $urandom);
    end
    n = 0;
    while (q.size() > 0 && n < 2000) begin step(1'($urandom), $urandom); n++; end
    chk("final_drain", q.size(), 0);
    chk("final_sat", ld_count, m_total > 256 ? 256 : m_total);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
